// File: rtl/mem_arb_if.sv
// Requester and memory-port signals of the IFU/LSU memory arbiter, grouped for mem_arb.
// slave is the arbiter's view; master is the view of whatever drives it.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

interface mem_arb_if;
    logic                    i_ifu_req;
    logic [`CPU_WIDTH-1:0]   i_ifu_addr;
    logic                    o_ifu_gnt;
    logic                    o_ifu_rvalid;
    logic [`CPU_WIDTH-1:0]   o_ifu_rdata;

    logic                    i_lsu_req;
    logic                    i_lsu_we;
    logic [`CPU_WIDTH-1:0]   i_lsu_addr;
    logic [`CPU_WIDTH-1:0]   i_lsu_wdata;
    logic [3:0]              i_lsu_wmask;
    logic                    o_lsu_gnt;
    logic                    o_lsu_rvalid;
    logic [`CPU_WIDTH-1:0]   o_lsu_rdata;

    logic                    o_mem_req;
    logic                    o_mem_we;
    logic [`CPU_WIDTH-1:0]   o_mem_addr;
    logic [`CPU_WIDTH-1:0]   o_mem_wdata;
    logic [3:0]              o_mem_wmask;
    logic                    i_mem_ready;
    logic                    i_mem_rvalid;
    logic [`CPU_WIDTH-1:0]   i_mem_rdata;

    modport slave (
        input  i_ifu_req, i_ifu_addr,
        input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata,
        output o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );

    modport master (
        output i_ifu_req, i_ifu_addr,
        output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata,
        input  o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );
endinterface

// File: rtl/mem_arb.sv
// IFU/LSU arbiter for one shared memory port, one transaction in flight (IDLE -> REQ -> RESP).
// Define MEM_ARB_RR_EN for a round-robin tie-break; default build gives the LSU fixed priority.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module mem_arb (
    input logic      i_clk,
    input logic      i_rst,
    mem_arb_if.slave bus_io
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic OwnIfu = 1'b0;
    localparam logic OwnLsu = 1'b1;

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [`CPU_WIDTH-1:0] addr_q, addr_d;
    logic [`CPU_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wmask_q, wmask_d;

    logic lsu_win;
    logic grant;
    logic in_req;
    logic resp_fire;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the requester that did not own the previous grant wins.
    assign lsu_win = bus_io.i_lsu_req & (~bus_io.i_ifu_req | (last_q == OwnIfu));
    assign last_d  = grant ? lsu_win : last_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            last_q <= OwnLsu;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign lsu_win = bus_io.i_lsu_req;
`endif

    // Reset gates grants and responses so nothing is handed out while i_rst is low.
    assign grant     = (state_q == StIdle) & i_rst & (bus_io.i_ifu_req | bus_io.i_lsu_req);
    assign in_req    = (state_q == StReq);
    assign resp_fire = (state_q == StResp) & i_rst & bus_io.i_mem_rvalid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StReq;
                    owner_d = lsu_win ? OwnLsu : OwnIfu;
                    we_d    = lsu_win & bus_io.i_lsu_we;
                    addr_d  = lsu_win ? bus_io.i_lsu_addr : bus_io.i_ifu_addr;
                    wdata_d = lsu_win ? bus_io.i_lsu_wdata : '0;
                    wmask_d = lsu_win ? bus_io.i_lsu_wmask : '0;
                end
            end
            StReq: begin
                if (bus_io.i_mem_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus_io.i_mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= StIdle;
            owner_q <= OwnIfu;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign bus_io.o_ifu_gnt = grant & ~lsu_win;
    assign bus_io.o_lsu_gnt = grant & lsu_win;

    assign bus_io.o_ifu_rvalid = resp_fire & (owner_q == OwnIfu);
    assign bus_io.o_lsu_rvalid = resp_fire & (owner_q == OwnLsu);
    assign bus_io.o_ifu_rdata  = bus_io.o_ifu_rvalid ? bus_io.i_mem_rdata : '0;
    assign bus_io.o_lsu_rdata  = bus_io.o_lsu_rvalid ? bus_io.i_mem_rdata : '0;

    // The command is only visible on the memory port while the request is pending.
    assign bus_io.o_mem_req   = in_req;
    assign bus_io.o_mem_we    = in_req & we_q;
    assign bus_io.o_mem_addr  = in_req ? addr_q : '0;
    assign bus_io.o_mem_wdata = in_req ? wdata_q : '0;
    assign bus_io.o_mem_wmask = in_req ? wmask_q : '0;
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
Parameters: none; all data and address widths are `CPU_WIDTH (32).
REQ-001 The block SHALL use one clock with synchronous, active-low reset, and expose exactly the ports below:
- i_clk  in  1  core clock; all state changes on its rising edge.
- i_rst  in  1  synchronous reset, active-low.
- i_ifu_req  in  1  IFU fetch request; held high until granted.
- i_ifu_addr  in  32  fetch address.
- o_ifu_gnt  out  1  one-cycle pulse; IFU request accepted.
- o_ifu_rvalid  out  1  one-cycle pulse; fetch data valid.
- o_ifu_rdata  out  32  fetch data.
- i_lsu_req  in  1  LSU request; held until granted.
- i_lsu_we  in  1  1 = store, 0 = load.
- i_lsu_addr  in  32  load/store address.
- i_lsu_wdata  in  32  store data.
- i_lsu_wmask  in  4  store byte mask.
- o_lsu_gnt  out  1  one-cycle pulse; LSU request accepted.
- o_lsu_rvalid  out  1  one-cycle pulse; load data valid or store acknowledged.
- o_lsu_rdata  out  32  load data.
- o_mem_req  out  1  request to the shared memory port.
- o_mem_we  out  1  write enable.
- o_mem_addr  out  32  memory address.
- o_mem_wdata  out  32  write data.
- o_mem_wmask  out  4  write byte mask.
- i_mem_ready  in  1  memory accepts o_mem_req this cycle.
- i_mem_rvalid  in  1  response valid (read data or write acknowledge).
- i_mem_rdata  in  32  read data.

Function
REQ-002 FSM states: IDLE, REQ, RESP; one transaction outstanding at most.
REQ-003 IDLE, one or both requests high: grant the winner combinationally; pulse its o_*_gnt; latch owner, we, addr, wdata and wmask; go to REQ next cycle.
REQ-004 IDLE, no request: stay in IDLE with all pulses 0.
REQ-005 REQ: drive o_mem_req=1 and the latched command; go to RESP on the cycle i_mem_ready=1.
REQ-006 REQ, i_mem_ready=0: hold o_mem_req and the command stable; no cycle limit.
REQ-007 RESP: o_mem_req=0; on i_mem_rvalid=1, pulse the owner's o_*_rvalid in the same cycle with o_*_rdata=i_mem_rdata, then go to IDLE.
REQ-008 Minimum cost is 3 cycles per transaction (grant, request, response); back-to-back grants are separated by at least one IDLE cycle.
REQ-009 i_mem_rvalid in IDLE or REQ SHALL be ignored; no rvalid pulse is produced.
REQ-010 Requester inputs that change after grant SHALL NOT affect the transaction in flight.
REQ-011 o_ifu_rvalid and o_lsu_rvalid SHALL never be high in the same cycle.
REQ-012 o_ifu_gnt and o_lsu_gnt SHALL never be high in the same cycle.
REQ-013 Tie-break (both requests high in IDLE) in default build: LSU wins.
REQ-014 Stores: o_lsu_rvalid pulses on the write acknowledge; o_lsu_rdata is don't-care.
REQ-015 In IDLE, o_mem_we, o_mem_addr, o_mem_wdata and o_mem_wmask SHALL be 0.

Reset
REQ-016 i_rst=0 at a clock edge: state to IDLE, latched command cleared, all outputs 0 in the following cycle.
REQ-017 Reset in REQ or RESP: the transaction is abandoned with no rvalid pulse; a later stale i_mem_rvalid is ignored per REQ-009.
REQ-018 While i_rst=0, no gnt pulse SHALL be issued regardless of requests.

Configuration
REQ-019 Macro MEM_ARB_RR_EN defined: the tie-break is round-robin. A 1-bit last-owner register updates on every grant, and the non-last requester wins a tie. After reset, last-owner = LSU, so the first tie goes to IFU.
REQ-020 MEM_ARB_RR_EN undefined: fixed LSU priority and no last-owner register.
REQ-021 Single (non-tied) requests SHALL behave identically in both builds.

Verification
REQ-022 IFU-only read: IFU req, addr 0x80000000, i_mem_ready immediate, rvalid one cycle later with rdata 0x00100093 -> o_ifu_gnt at cycle 0, o_mem_req at cycle 1, o_ifu_rvalid with 0x00100093 at cycle 2.
REQ-023 LSU store: addr 0x80001000, wdata 0xDEADBEEF, mask 0xF -> o_mem_we=1 with the same addr, data and mask during REQ; o_lsu_rvalid on the acknowledge; o_ifu_rvalid stays 0.
REQ-024 Tie: both requests high in IDLE -> default build grants LSU first and IFU in the next IDLE. With MEM_ARB_RR_EN, the first tie after reset goes to IFU and the next tie to LSU.
REQ-025 Backpressure: i_mem_ready low for 5 cycles -> o_mem_req and o_mem_addr held constant for all 5 cycles, even though i_ifu_addr changes after grant.
REQ-026 Reset in RESP, then i_mem_rvalid=1 two cycles after reset is released -> no rvalid pulse; state IDLE; the next request is served normally.
REQ-027 Stray i_mem_rvalid=1 in IDLE -> both o_*_rvalid stay 0.
